// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_pkg                                                            |
// | Shared FSM encoding, register map and defaults for the video DMA.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package video_pkg;

  typedef enum logic [1:0] {
    VDMA_IDLE = 2'd0,
    VDMA_RD   = 2'd1,
    VDMA_WR   = 2'd2,
    VDMA_ADV  = 2'd3
  } vdma_state_e;

  localparam logic [2:0] REG_SRC_L  = 3'd0;
  localparam logic [2:0] REG_SRC_H  = 3'd1;
  localparam logic [2:0] REG_DST_L  = 3'd2;
  localparam logic [2:0] REG_DST_H  = 3'd3;
  localparam logic [2:0] REG_WIDTH  = 3'd4;
  localparam logic [2:0] REG_HEIGHT = 3'd5;

  localparam logic [15:0] DST_STRIDE_DEF = 16'h0100;

endpackage
`default_nettype wire

// File: rtl/video_dma_addr_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_dma_addr_ctr                                                   |
// | Loadable address counter with increment and add-stride; wraps mod 2^N|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module video_dma_addr_ctr #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  input  logic              add,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] cnt
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Load wins over add, add over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (add) begin
      cnt_d = cnt_q + stride;
    end else if (inc) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/video_dma_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | video_dma_addr_gen                                                   |
// | 2-D blit address generator: picture ROM -> video RAM, row stride.    |
// | Option macro: VIDEO_DMA_TRANSPARENCY_EN (skip writes of 8'h00).      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module video_dma_addr_gen
  import video_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] DST_STRIDE = ADDR_W'(DST_STRIDE_DEF)
) (
  input  logic              CLK,
  input  logic              RST_AL,
  input  logic [7:0]        DB,
  input  logic              REG_WR,
  input  logic [2:0]        REG_SEL,
  input  logic              START,
  input  logic              ABORT,
  output logic              RD_REQ,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [7:0]        RD_DATA,
  input  logic              RD_ACK,
  output logic              WR_REQ,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA,
  input  logic              WR_ACK,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] ST_IDLE = VDMA_IDLE;
  localparam logic [1:0] ST_RD   = VDMA_RD;
  localparam logic [1:0] ST_WR   = VDMA_WR;
  localparam logic [1:0] ST_ADV  = VDMA_ADV;

  logic [1:0]  state_q,   state_d;
  logic [15:0] src_reg_q, src_reg_d;
  logic [15:0] dst_reg_q, dst_reg_d;
  logic [7:0]  width_q,   width_d;
  logic [7:0]  height_q,  height_d;
  logic [7:0]  col_q,     col_d;
  logic [7:0]  row_q,     row_d;
  logic [7:0]  data_q,    data_d;
  logic        done_q,    done_d;

  logic              src_load, src_inc;
  logic              dst_load, dst_inc;
  logic              rb_load,  rb_add;
  logic [ADDR_W-1:0] src_cnt, dst_cnt, rb_cnt;
  logic [ADDR_W-1:0] dst_load_val;

  always_comb begin
    state_d   = state_q;
    src_reg_d = src_reg_q;
    dst_reg_d = dst_reg_q;
    width_d   = width_q;
    height_d  = height_q;
    col_d     = col_q;
    row_d     = row_q;
    data_d    = data_q;
    done_d    = 1'b0;
    src_load  = 1'b0;
    src_inc   = 1'b0;
    dst_load  = 1'b0;
    dst_inc   = 1'b0;
    rb_load   = 1'b0;
    rb_add    = 1'b0;

    if (state_q == ST_IDLE && REG_WR) begin
      case (REG_SEL)
        REG_SRC_L:  src_reg_d[7:0]  = DB;
        REG_SRC_H:  src_reg_d[15:8] = DB;
        REG_DST_L:  dst_reg_d[7:0]  = DB;
        REG_DST_H:  dst_reg_d[15:8] = DB;
        REG_WIDTH:  width_d         = DB;
        REG_HEIGHT: height_d        = DB;
        default:    ;
      endcase
    end

    // ABORT overrides every transition, including a same-cycle ack.
    if (ABORT) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_d  = ST_RD;
            src_load = 1'b1;
            dst_load = 1'b1;
            rb_load  = 1'b1;
            col_d    = width_q;
            row_d    = height_q;
          end
        end
        ST_RD: begin
          if (RD_ACK) begin
            data_d  = RD_DATA;
`ifdef VIDEO_DMA_TRANSPARENCY_EN
            state_d = (RD_DATA == 8'h00) ? ST_ADV : ST_WR;
`else
            state_d = ST_WR;
`endif
          end
        end
        ST_WR: begin
          if (WR_ACK) begin
            state_d = ST_ADV;
          end
        end
        default: begin
          if (col_q != 8'd0) begin
            src_inc = 1'b1;
            dst_inc = 1'b1;
            col_d   = col_q - 8'd1;
            state_d = ST_RD;
          end else if (row_q != 8'd0) begin
            src_inc  = 1'b1;
            rb_add   = 1'b1;
            dst_load = 1'b1;
            col_d    = width_q;
            row_d    = row_q - 8'd1;
            state_d  = ST_RD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // At a row end dst takes the row base the base counter is moving to.
  assign dst_load_val = (state_q == ST_IDLE) ? ADDR_W'(dst_reg_q) : rb_cnt + DST_STRIDE;

  video_dma_addr_ctr #(.ADDR_W(ADDR_W)) u_src_ctr (
    .clk(CLK), .rst_n(RST_AL), .load(src_load), .load_val(ADDR_W'(src_reg_q)),
    .inc(src_inc), .add(1'b0), .stride('0), .cnt(src_cnt)
  );

  video_dma_addr_ctr #(.ADDR_W(ADDR_W)) u_dst_ctr (
    .clk(CLK), .rst_n(RST_AL), .load(dst_load), .load_val(dst_load_val),
    .inc(dst_inc), .add(1'b0), .stride('0), .cnt(dst_cnt)
  );

  video_dma_addr_ctr #(.ADDR_W(ADDR_W)) u_rb_ctr (
    .clk(CLK), .rst_n(RST_AL), .load(rb_load), .load_val(ADDR_W'(dst_reg_q)),
    .inc(1'b0), .add(rb_add), .stride(DST_STRIDE), .cnt(rb_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!RST_AL) begin
      state_q   <= ST_IDLE;
      src_reg_q <= '0;
      dst_reg_q <= '0;
      width_q   <= '0;
      height_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_reg_q <= src_reg_d;
      dst_reg_q <= dst_reg_d;
      width_q   <= width_d;
      height_q  <= height_d;
      col_q     <= col_d;
      row_q     <= row_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign RD_REQ  = (state_q == ST_RD);
  assign WR_REQ  = (state_q == ST_WR);
  assign RD_ADDR = RD_REQ ? src_cnt : '0;
  assign WR_ADDR = WR_REQ ? dst_cnt : '0;
  assign WR_DATA = WR_REQ ? data_q  : 8'h00;
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_video_dma_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_video_dma_addr_gen                                                |
// | Scoreboarded bench: expected reads/writes queued per blit, popped on |
// | each DUT handshake. Honours VIDEO_DMA_TRANSPARENCY_EN. Rev 1.0       |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_video_dma_addr_gen;
  import video_pkg::*;

  localparam logic [15:0] STRIDE = 16'h0100;

  logic        CLK = 1'b0;
  logic        RST_AL = 1'b0;
  logic [7:0]  DB = 8'h00;
  logic        REG_WR = 1'b0;
  logic [2:0]  REG_SEL = 3'd0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        RD_REQ;
  logic [15:0] RD_ADDR;
  logic [7:0]  RD_DATA = 8'h00;
  logic        RD_ACK = 1'b0;
  logic        WR_REQ;
  logic [15:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        WR_ACK = 1'b0;
  logic        BUSY;
  logic        DONE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rom [256];
  logic [15:0] exp_rd [$];
  logic [23:0] exp_wr [$];

  always #5 CLK = ~CLK;

  video_dma_addr_gen #(.ADDR_W(16), .DST_STRIDE(STRIDE)) dut (
    .CLK(CLK), .RST_AL(RST_AL), .DB(DB), .REG_WR(REG_WR), .REG_SEL(REG_SEL),
    .START(START), .ABORT(ABORT),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_ACK(RD_ACK),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
    .BUSY(BUSY), .DONE(DONE)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] sel, input logic [7:0] val);
    REG_WR = 1'b1; REG_SEL = sel; DB = val;
    @(posedge CLK); #1;
    REG_WR = 1'b0;
  endtask

  task automatic program_blit(input logic [15:0] src, input logic [15:0] dst,
                              input logic [7:0] w, input logic [7:0] h);
    write_reg(REG_SRC_L, src[7:0]);
    write_reg(REG_SRC_H, src[15:8]);
    write_reg(REG_DST_L, dst[7:0]);
    write_reg(REG_DST_H, dst[15:8]);
    write_reg(REG_WIDTH, w);
    write_reg(REG_HEIGHT, h);
  endtask

  // Queues the expected transactions, then starts the DUT and services its handshakes.
  task automatic run_blit(input string tag, input logic [15:0] src, input logic [15:0] dst,
                          input logic [7:0] w, input logic [7:0] h,
                          input int rd_dly, input int wr_dly,
                          input int abort_wr, input int rst_cyc, input int bwr_cyc);
    logic [15:0] a, wa, rd_hold;
    logic [7:0]  d;
    int exp_cyc, cyc, done_cnt, done_cyc, overlap, unstable;
    int rd_wait, wr_wait, wr_n, extra_rd, extra_wr, timed_out;
    bit aborted, did_rst;
    exp_cyc = 0; done_cnt = 0; done_cyc = -1; overlap = 0; unstable = 0;
    rd_wait = 0; wr_wait = 0; wr_n = 0; extra_rd = 0; extra_wr = 0; timed_out = 0;
    aborted = 1'b0; did_rst = 1'b0; rd_hold = 16'h0;
    exp_rd.delete(); exp_wr.delete();

    for (int r = 0; r <= int'(h); r++) begin
      for (int c = 0; c <= int'(w); c++) begin
        a  = src + 16'(r * (int'(w) + 1) + c);
        wa = dst + 16'(r) * STRIDE + 16'(c);
        d  = rom[a[7:0]];
        exp_rd.push_back(a);
        exp_cyc += rd_dly + 2;
`ifdef VIDEO_DMA_TRANSPARENCY_EN
        if (d != 8'h00) begin
          exp_wr.push_back({wa, d});
          exp_cyc += wr_dly + 1;
        end
`else
        exp_wr.push_back({wa, d});
        exp_cyc += wr_dly + 1;
`endif
      end
    end

    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check_eq({tag, "_req_first"}, RD_REQ, 1);

    cyc = 0;
    while (1) begin
      if (cyc >= 4000) begin timed_out = 1; break; end
      if (RD_REQ && WR_REQ) overlap++;
      if (DONE) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (!BUSY) break;

      RD_ACK = (rd_dly == 0); WR_ACK = (wr_dly == 0);
      ABORT = 1'b0; REG_WR = 1'b0; START = 1'b0;
      RD_DATA = rom[RD_ADDR[7:0]];

      if (RD_REQ) begin
        if (rd_wait == 0) rd_hold = RD_ADDR;
        else if (RD_ADDR != rd_hold) unstable++;
        if (rd_wait >= rd_dly) begin
          RD_ACK = 1'b1; rd_wait = 0;
          if (exp_rd.size() == 0) extra_rd++;
          else check_eq({tag, "_rd_addr"}, RD_ADDR, exp_rd.pop_front());
        end else rd_wait++;
      end else rd_wait = 0;

      if (WR_REQ) begin
        if (wr_wait >= wr_dly) begin
          WR_ACK = 1'b1; wr_wait = 0; wr_n++;
          if (exp_wr.size() == 0) extra_wr++;
          else check_eq({tag, "_wr_addr_data"}, {WR_ADDR, WR_DATA}, exp_wr.pop_front());
          if (wr_n == abort_wr) begin ABORT = 1'b1; aborted = 1'b1; end
        end else wr_wait++;
      end else wr_wait = 0;

      if (cyc == bwr_cyc) begin
        REG_WR = 1'b1; REG_SEL = REG_DST_L; DB = 8'hEE; START = 1'b1;
      end
      if (cyc == rst_cyc) begin RST_AL = 1'b0; did_rst = 1'b1; end

      @(posedge CLK); #1;
      cyc++;
      RD_ACK = 1'b0; WR_ACK = 1'b0; ABORT = 1'b0; REG_WR = 1'b0; START = 1'b0;
      if (aborted || did_rst) break;
    end

    check_eq({tag, "_timeout"}, timed_out, 0);
    check_eq({tag, "_req_overlap"}, overlap, 0);
    check_eq({tag, "_rd_addr_unstable"}, unstable, 0);

    if (aborted) begin
      check_eq({tag, "_abort_idle"}, {BUSY, RD_REQ, WR_REQ, DONE}, 4'b0000);
      repeat (3) begin
        if (DONE) done_cnt++;
        @(posedge CLK); #1;
      end
      check_eq({tag, "_abort_no_done"}, done_cnt, 0);
    end else if (did_rst) begin
      check_eq({tag, "_rst_outputs"},
               {RD_REQ, WR_REQ, BUSY, DONE, RD_ADDR, WR_ADDR, WR_DATA}, 64'h0);
      RST_AL = 1'b1;
      @(posedge CLK); #1;
      check_eq({tag, "_rst_release_idle"}, {RD_REQ, WR_REQ, BUSY, DONE}, 4'b0000);
    end else begin
      check_eq({tag, "_done_count"}, done_cnt, 1);
      check_eq({tag, "_done_cycle"}, done_cyc, exp_cyc);
      check_eq({tag, "_rd_left"}, exp_rd.size(), 0);
      check_eq({tag, "_wr_left"}, exp_wr.size(), 0);
      check_eq({tag, "_extra_xfers"}, extra_rd + extra_wr, 0);
      @(posedge CLK); #1;
      check_eq({tag, "_done_one_cycle"}, DONE, 0);
    end
    exp_rd.delete(); exp_wr.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5C;

    RST_AL = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("reset_outputs", {RD_REQ, WR_REQ, BUSY, DONE, RD_ADDR, WR_ADDR, WR_DATA}, 64'h0);
    RST_AL = 1'b1;
    @(posedge CLK); #1;

    program_blit(16'h1000, 16'h2000, 8'd1, 8'd1);
    run_blit("basic", 16'h1000, 16'h2000, 8'd1, 8'd1, 0, 0, -1, -1, -1);
    run_blit("repeat_slow", 16'h1000, 16'h2000, 8'd1, 8'd1, 3, 1, -1, -1, -1);

    program_blit(16'hFFFF, 16'h2000, 8'd1, 8'd0);
    run_blit("src_wrap", 16'hFFFF, 16'h2000, 8'd1, 8'd0, 0, 0, -1, -1, -1);

    program_blit(16'h1000, 16'h2000, 8'd2, 8'd1);
    run_blit("abort", 16'h1000, 16'h2000, 8'd2, 8'd1, 1, 0, 2, -1, -1);
    run_blit("after_abort", 16'h1000, 16'h2000, 8'd2, 8'd1, 1, 0, -1, -1, -1);

    rom[8'h10] = 8'h00; rom[8'h11] = 8'h5A; rom[8'h12] = 8'h00;
    program_blit(16'h3010, 16'h4000, 8'd2, 8'd0);
    run_blit("zero_bytes", 16'h3010, 16'h4000, 8'd2, 8'd0, 0, 2, -1, -1, -1);

    program_blit(16'h1000, 16'h2000, 8'd1, 8'd1);
    run_blit("busy_wr", 16'h1000, 16'h2000, 8'd1, 8'd1, 0, 0, -1, -1, 1);
    run_blit("mid_reset", 16'h1000, 16'h2000, 8'd1, 8'd1, 0, 0, -1, 4, -1);
    run_blit("post_reset_regs", 16'h0000, 16'h0000, 8'd0, 8'd0, 0, 0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
